// File: rtl/noc_merge_arbiter_if.sv
// Handshake bundle between the NUM_IN input channels, the merge arbiter and the single output channel.
// The arbiter takes the master modport; the surrounding router fabric takes the slave modport.
interface noc_merge_arbiter_if #(
  parameter int NUM_IN = 4,
  parameter int W      = 9
);
  localparam int SRC_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

  logic [NUM_IN-1:0]   in_valid;
  logic [NUM_IN*W-1:0] in_data;
  logic [NUM_IN-1:0]   in_ready;
  logic                out_valid;
  logic [W-1:0]        out_data;
  logic                out_ready;
  logic [SRC_W-1:0]    out_src;

  modport master (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output out_src
  );

  modport slave (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_src
  );
endinterface

// File: rtl/noc_merge_arbiter.sv
// Round-robin merge of NUM_IN single-flit streams into one registered output channel,
// with a saturating count of flits delivered downstream.
module noc_merge_arbiter_chk #(
  parameter int NUM_IN = 4,
  parameter int W      = 9,
  parameter int SRC_W  = 2
) (
  input logic              clk,
  input logic              reset,
  input logic [NUM_IN-1:0] in_ready,
  input logic              can_load,
  input logic              out_valid,
  input logic              out_ready,
  input logic [W-1:0]      out_data,
  input logic [SRC_W-1:0]  out_src,
  input logic [SRC_W-1:0]  rr_ptr
);
  a_ready_onehot: assert property (@(posedge clk) $onehot0(in_ready))
    else $error("in_ready has more than one bit set");

  a_reset_quiet: assert property (@(posedge clk) reset |-> (in_ready == {NUM_IN{1'b0}}))
    else $error("in_ready asserted during reset");

  a_ready_needs_load: assert property (@(posedge clk) (|in_ready) |-> can_load)
    else $error("in_ready asserted while output register cannot load");

  a_ptr_range: assert property (@(posedge clk) disable iff (reset) (int'(rr_ptr) < NUM_IN))
    else $error("round-robin pointer out of range");

  a_hold_stalled: assert property (@(posedge clk) disable iff (reset)
      (out_valid && !out_ready) |=> (out_valid && $stable(out_data) && $stable(out_src)))
    else $error("stalled output flit changed");
endmodule

module noc_merge_arbiter #(
  parameter int NUM_IN = 4,
  parameter int W      = 9,
  parameter int CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  noc_merge_arbiter_if.master   bus,
  output logic [CNT_W-1:0]      fwd_count
);
  localparam int SRC_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [NUM_IN-1:0] OH_ONE = {{(NUM_IN-1){1'b0}}, 1'b1};

  logic               out_valid_r;
  logic [W-1:0]       out_data_r;
  logic [SRC_W-1:0]   out_src_r;
  logic [SRC_W-1:0]   rr_ptr_r;
  logic [CNT_W-1:0]   fwd_count_r;

  logic               can_load_s;
  logic               grant_vld_s;
  logic               take_s;
  logic               hit_s;
  logic [SRC_W-1:0]   cand_s;
  logic [SRC_W-1:0]   grant_idx_s;
  logic [SRC_W-1:0]   next_ptr_s;
  logic [W-1:0]       grant_data_s;
  logic [NUM_IN-1:0]  grant_oh_s;

  // Modulo-NUM_IN step used for both the search order and the pointer advance.
  function automatic logic [SRC_W-1:0] rr_index(input logic [SRC_W-1:0] base, input int offset);
    int sum_v;
    sum_v = int'(base) + offset;
    return (sum_v >= NUM_IN) ? SRC_W'(sum_v - NUM_IN) : SRC_W'(sum_v);
  endfunction

  assign can_load_s = !out_valid_r || bus.out_ready;

  // First valid input at or after rr_ptr, wrapping modulo NUM_IN.
  always_comb begin
    grant_vld_s = 1'b0;
    grant_idx_s = {SRC_W{1'b0}};
    cand_s      = {SRC_W{1'b0}};
    hit_s       = 1'b0;
    for (int k = 0; k < NUM_IN; k++) begin
      cand_s      = rr_index(rr_ptr_r, k);
      hit_s       = !grant_vld_s && bus.in_valid[cand_s];
      grant_idx_s = hit_s ? cand_s : grant_idx_s;
      grant_vld_s = grant_vld_s || hit_s;
    end
  end

  // Grant decode; reset suppresses every ready in its own cycle.
  always_comb begin
    grant_data_s = bus.in_data[int'(grant_idx_s)*W +: W];
    next_ptr_s   = rr_index(grant_idx_s, 1);
    take_s       = can_load_s && grant_vld_s && !reset;
    if (take_s) begin
      grant_oh_s = OH_ONE << grant_idx_s;
    end else begin
      grant_oh_s = {NUM_IN{1'b0}};
    end
  end

  // Output register, source tag and round-robin pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_r <= 1'b0;
      out_data_r  <= {W{1'b0}};
      out_src_r   <= {SRC_W{1'b0}};
      rr_ptr_r    <= {SRC_W{1'b0}};
    end else if (can_load_s) begin
      out_valid_r <= grant_vld_s;
      if (grant_vld_s) begin
        out_data_r <= grant_data_s;
        out_src_r  <= grant_idx_s;
        rr_ptr_r   <= next_ptr_s;
      end
    end
  end

  // Saturating count of flits taken downstream.
  always_ff @(posedge clk) begin
    if (reset) begin
      fwd_count_r <= {CNT_W{1'b0}};
    end else if (out_valid_r && bus.out_ready && (fwd_count_r != CNT_MAX)) begin
      fwd_count_r <= fwd_count_r + CNT_ONE;
    end
  end

  assign bus.in_ready  = grant_oh_s;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign bus.out_src   = out_src_r;
  assign fwd_count     = fwd_count_r;

  noc_merge_arbiter_chk #(
    .NUM_IN (NUM_IN),
    .W      (W),
    .SRC_W  (SRC_W)
  ) u_chk (
    .clk       (clk),
    .reset     (reset),
    .in_ready  (grant_oh_s),
    .can_load  (can_load_s),
    .out_valid (out_valid_r),
    .out_ready (bus.out_ready),
    .out_data  (out_data_r),
    .out_src   (out_src_r),
    .rr_ptr    (rr_ptr_r)
  );
endmodule
